// File: rtl/image_select_ctrl_pkg.sv
// Shared constants and helpers for the image-bank selector.
//   NUM_IMAGES_DEF : default number of image banks
//   BANK_STEP      : distance between consecutive bank codes on sel
//   SEL_W          : width of the bank code bus
//   mode_e         : MANUAL/AUTO state encodings
//   idx_wrap_step  : next/previous index with wrap-around
package image_select_ctrl_pkg;

  localparam int unsigned NUM_IMAGES_DEF = 32'd7;
  localparam int unsigned BANK_STEP      = 32'd2;
  localparam int unsigned SEL_W          = 32'd8;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Step an index up or down by one inside 0..n-1, wrapping at both ends.
  function automatic int unsigned idx_wrap_step(input int unsigned idx,
                                                input int unsigned n,
                                                input logic        up);
    if (up) begin
      return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
    end else begin
      return (idx == 32'd0) ? n - 32'd1 : idx - 32'd1;
    end
  endfunction

endpackage

// File: rtl/image_select_ctrl_if.sv
// Button/vsync inputs and selector outputs of image_select_ctrl.
//   btn_next/btn_prev/btn_mode : raw active-high buttons
//   vsync                      : active-low display vsync (pixel-clock domain)
//   sel                        : committed bank code
//   auto_mode                  : slideshow active
//   pending                    : a selection change waits for frame start
// master drives the inputs and observes the outputs; slave is the controller.
interface image_select_ctrl_if import image_select_ctrl_pkg::*;;
  logic             btn_next;
  logic             btn_prev;
  logic             btn_mode;
  logic             vsync;
  logic [SEL_W-1:0] sel;
  logic             auto_mode;
  logic             pending;

  modport master (output btn_next, btn_prev, btn_mode, vsync,
                  input  sel, auto_mode, pending);
  modport slave  (input  btn_next, btn_prev, btn_mode, vsync,
                  output sel, auto_mode, pending);
endinterface

// File: rtl/image_select_ctrl_button_debounce.sv
// Two-flop synchronizer, counter debounce and rising-edge press pulse for
// one raw push-button.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   press    : one-cycle pulse on an accepted 0->1 transition
module image_select_ctrl_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter int unsigned CNT_W           = 32'd20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic             meta_r;
  logic             sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic             deb_r;
  logic             deb_q_r;
  logic             press_r;

  // Synchronize, debounce and detect the accepted rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      cnt_r   <= '0;
      deb_r   <= 1'b0;
      deb_q_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      meta_r  <= btn;
      sync_r  <= meta_r;
      deb_q_r <= deb_r;
      press_r <= deb_r & ~deb_q_r;
      if (sync_r == deb_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 32'd1)) begin
        // Level held long enough: accept it.
        cnt_r <= '0;
        deb_r <= sync_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/image_select_ctrl.sv
// Turns next/prev/mode buttons into the image-bank selector code. Manual
// stepping or auto slideshow; selection changes are committed only at frame
// start (vsync falling edge) so a frame never mixes banks.
//   clk, rst : clock, synchronous active-high reset
//   bus      : image_select_ctrl_if.slave (buttons, vsync, sel, auto_mode, pending)
module image_select_ctrl import image_select_ctrl_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter int unsigned NUM_IMAGES      = NUM_IMAGES_DEF,
  parameter int unsigned AUTO_FRAMES     = 32'd180,
  parameter int unsigned CNT_W           = 32'd20
) (
  input  logic                clk,
  input  logic                rst,
  image_select_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_IMAGES);
  localparam int unsigned FC_W  = $clog2(AUTO_FRAMES + 32'd1);

  logic next_p_s, prev_p_s, mode_p_s;

  image_select_ctrl_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
    u_deb_next (.clk(clk), .rst(rst), .btn(bus.btn_next), .press(next_p_s));
  image_select_ctrl_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
    u_deb_prev (.clk(clk), .rst(rst), .btn(bus.btn_prev), .press(prev_p_s));
  image_select_ctrl_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
    u_deb_mode (.clk(clk), .rst(rst), .btn(bus.btn_mode), .press(mode_p_s));

  logic vs_meta_r, vs_sync_r, vs_prev_r, frame_start_r;

  // Bring vsync into clk domain and flag its falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_meta_r     <= 1'b0;
      vs_sync_r     <= 1'b0;
      vs_prev_r     <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      vs_meta_r     <= bus.vsync;
      vs_sync_r     <= vs_meta_r;
      vs_prev_r     <= vs_sync_r;
      frame_start_r <= vs_prev_r & ~vs_sync_r;
    end
  end

  mode_e            state_r, state_nx_s;
  logic [FC_W-1:0]  frame_cnt_r, frame_cnt_nx_s;
  logic             auto_adv_s;
  logic             auto_mode_r;

  // Mode state, frame counter and registered auto_mode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= MODE_MANUAL;
      frame_cnt_r <= '0;
      auto_mode_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      frame_cnt_r <= frame_cnt_nx_s;
      auto_mode_r <= (state_nx_s == MODE_AUTO);
    end
  end

  // Mode transitions and slideshow frame counting.
  always_comb begin
    state_nx_s     = state_r;
    frame_cnt_nx_s = frame_cnt_r;
    auto_adv_s     = 1'b0;
    case (state_r)
      MODE_MANUAL: begin
        frame_cnt_nx_s = '0;
        if (mode_p_s) begin
          state_nx_s = MODE_AUTO;
        end else begin
          state_nx_s = MODE_MANUAL;
        end
      end
      MODE_AUTO: begin
        if (mode_p_s) begin
          state_nx_s     = MODE_MANUAL;
          frame_cnt_nx_s = '0;
        end else if (next_p_s || prev_p_s) begin
          // A manual press restarts the slide time and suppresses the auto step.
          frame_cnt_nx_s = '0;
        end else if (frame_start_r) begin
          if (frame_cnt_r == FC_W'(AUTO_FRAMES - 32'd1)) begin
            frame_cnt_nx_s = '0;
            auto_adv_s     = 1'b1;
          end else begin
            frame_cnt_nx_s = frame_cnt_r + FC_W'(1);
          end
        end else begin
          frame_cnt_nx_s = frame_cnt_r;
        end
      end
      default: begin
        state_nx_s     = MODE_MANUAL;
        frame_cnt_nx_s = '0;
      end
    endcase
  end

  logic [IDX_W-1:0] next_idx_r, next_idx_s;
  logic [IDX_W-1:0] cur_idx_r, cur_idx_s;
  logic [SEL_W-1:0] sel_r;
  logic             pending_r;

  // Pending index update; simultaneous next+prev cancel each other.
  always_comb begin
    next_idx_s = next_idx_r;
    if (next_p_s && prev_p_s) begin
      next_idx_s = next_idx_r;
    end else if (next_p_s || auto_adv_s) begin
      next_idx_s = IDX_W'(idx_wrap_step(32'(next_idx_r), NUM_IMAGES, 1'b1));
    end else if (prev_p_s) begin
      next_idx_s = IDX_W'(idx_wrap_step(32'(next_idx_r), NUM_IMAGES, 1'b0));
    end else begin
      next_idx_s = next_idx_r;
    end
  end

  // Commit takes the pre-update next index, so a same-cycle update waits a frame.
  always_comb begin
    cur_idx_s = cur_idx_r;
    if (frame_start_r) begin
      cur_idx_s = next_idx_r;
    end else begin
      cur_idx_s = cur_idx_r;
    end
  end

  // Index registers, committed bank code and pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_idx_r <= '0;
      cur_idx_r  <= '0;
      sel_r      <= '0;
      pending_r  <= 1'b0;
    end else begin
      next_idx_r <= next_idx_s;
      cur_idx_r  <= cur_idx_s;
      pending_r  <= (next_idx_s != cur_idx_s);
      if (frame_start_r) begin
        sel_r <= SEL_W'(next_idx_r) * SEL_W'(BANK_STEP);
      end
    end
  end

  assign bus.sel       = sel_r;
  assign bus.auto_mode = auto_mode_r;
  assign bus.pending   = pending_r;

endmodule
